mskaes_32bits_state_ctrl: RTL and testbench

- Sequencing FSM for the masked 32-bit AES-128 encryption state datapath.
- Accepts a plaintext load request, then drives the datapath routing controls (init, en_MC, en_loop, enable) through 10 rounds and a final AddRoundKey pass.
- Tells the key schedule which column and round key to present, and hands the ciphertext off through a valid/ready handshake.
- Controls only; it carries no shared data.

---
 rtl/mskaes_32bits_state_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mskaes_32bits_state_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_32bits_state_ctrl.sv
// Sequencing controller for the masked 32-bit AES-128 encryption state datapath.
// Walks one block through LOAD, ten rounds of ISSUE/WAIT/RET, a FINAL key
// addition and an OUT hand-off. It drives routing controls only and never
// touches shared data.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both 1.
// in_valid/in_ready: in_ready=1 only in IDLE, and in_valid is ignored in every
// other state. out_valid/out_ready: out_valid=1 only in OUT and stays high until
// out_ready is seen. out_valid does not depend on out_ready within the cycle.
module mskaes_32bits_state_ctrl #(
  parameter int SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       init,
  output logic       enable,
  output logic       en_MC,
  output logic       en_loop,
  output logic       key_col_en,
  output logic [1:0] key_col_idx,
  output logic [3:0] key_rnd,
  output logic       busy
);

  // The S-box pipeline depth must fit the 4-bit WAIT counter and cover one column burst.
  if (SBOX_LAT < 4 || SBOX_LAT > 15) begin : g_bad_lat
    $error("mskaes_32bits_state_ctrl: SBOX_LAT must be in 4..15");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RET   = 3'd4,
    S_FINAL = 3'd5,
    S_OUT   = 3'd6
  } state_t;

  // The last WAIT count is only used when SBOX_LAT > 4, so it never has to go negative.
  localparam logic [3:0] WAIT_LAST = (SBOX_LAT > 4) ? 4'(SBOX_LAT - 5) : 4'd0;
  localparam logic       HAS_WAIT  = (SBOX_LAT > 4);

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] wait_q, wait_d;

  // State and counter registers; reset returns to IDLE with every counter cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= 2'd0;
      rnd_q   <= 4'd0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      rnd_q   <= rnd_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and counter updates. The column counter wraps 3->0 as each phase exits.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    rnd_d   = rnd_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ISSUE;
        col_d   = 2'd0;
        rnd_d   = 4'd0;
      end
      S_ISSUE: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          wait_d  = 4'd0;
          state_d = HAS_WAIT ? S_WAIT : S_RET;
        end
      end
      S_WAIT: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == WAIT_LAST) begin
          wait_d  = 4'd0;
          state_d = S_RET;
        end
      end
      S_RET: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          if (rnd_q == 4'd9) begin
            rnd_d   = 4'd10;
            state_d = S_FINAL;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINAL: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          col_d   = 2'd0;
          rnd_d   = 4'd0;
          wait_d  = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        col_d   = 2'd0;
        rnd_d   = 4'd0;
        wait_d  = 4'd0;
      end
    endcase
  end

  // Moore output decode from registered state and counters. The key fields read 0
  // whenever no column is requested.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    init        = 1'b0;
    enable      = 1'b0;
    en_MC       = 1'b0;
    en_loop     = 1'b0;
    key_col_en  = 1'b0;
    key_col_idx = 2'd0;
    key_rnd     = 4'd0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_LOAD: begin
        init   = 1'b1;
        enable = 1'b1;
        busy   = 1'b1;
      end
      S_ISSUE: begin
        enable      = 1'b1;
        key_col_en  = 1'b1;
        key_col_idx = col_q;
        key_rnd     = rnd_q;
        busy        = 1'b1;
      end
      S_WAIT: begin
        busy = 1'b1;
      end
      S_RET: begin
        enable = 1'b1;
        en_MC  = (rnd_q != 4'd9);
        busy   = 1'b1;
      end
      S_FINAL: begin
        enable      = 1'b1;
        en_loop     = 1'b1;
        key_col_en  = 1'b1;
        key_col_idx = col_q;
        key_rnd     = rnd_q;
        busy        = 1'b1;
      end
      S_OUT: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mskaes_32bits_state_ctrl.sv
// Bench for the AES state controller. It runs two instances, with SBOX_LAT=4
// and SBOX_LAT=6, from the same inputs. A schedule model predicts the outputs
// of each instance on every cycle.
module tb_mskaes_32bits_state_ctrl;

  // Output vector layout:
  // {in_ready, out_valid, init, enable, en_MC, en_loop, key_col_en, idx[1:0], rnd[3:0], busy}
  localparam int W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       ir4, ov4, in4, en4, mc4, lp4, kc4, bz4;
  logic [1:0] ci4;
  logic [3:0] kr4;
  logic       ir6, ov6, in6, en6, mc6, lp6, kc6, bz6;
  logic [1:0] ci6;
  logic [3:0] kr6;

  mskaes_32bits_state_ctrl #(.SBOX_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .out_valid(ov4), .out_ready(out_ready), .init(in4), .enable(en4),
    .en_MC(mc4), .en_loop(lp4), .key_col_en(kc4), .key_col_idx(ci4),
    .key_rnd(kr4), .busy(bz4)
  );

  mskaes_32bits_state_ctrl #(.SBOX_LAT(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6),
    .out_valid(ov6), .out_ready(out_ready), .init(in6), .enable(en6),
    .en_MC(mc6), .en_loop(lp6), .key_col_en(kc6), .key_col_idx(ci6),
    .key_rnd(kr6), .busy(bz6)
  );

  logic [W-1:0] act [2];
  assign act[0] = {ir4, ov4, in4, en4, mc4, lp4, kc4, ci4, kr4, bz4};
  assign act[1] = {ir6, ov6, in6, en6, mc6, lp6, kc6, ci6, kr6, bz6};

  // ---------------- behavioural model ----------------
  int lat [2] = '{4, 6};

  // Number of busy cycles in one block: LOAD, 10 rounds of (lat+4), then 4 FINAL.
  function automatic int run_len(input int l);
    return 1 + 10 * (l + 4) + 4;
  endfunction

  // Expected outputs at busy-cycle index t, where t=0 is LOAD.
  function automatic logic [W-1:0] exp_run(input int l, input int t);
    int rl, u, r, p;
    logic e, mc, lp, kc;
    logic [1:0] idx;
    logic [3:0] rnd;
    e = 0; mc = 0; lp = 0; kc = 0; idx = 0; rnd = 0;
    rl = l + 4;
    if (t == 0) begin
      return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1};
    end
    u = t - 1;
    if (u < 10 * rl) begin
      r = u / rl;
      p = u % rl;
      if (p < 4) begin
        e = 1; kc = 1; idx = 2'(p); rnd = 4'(r);
      end else if (p >= l) begin
        e = 1; mc = (r < 9);
      end
    end else begin
      e = 1; lp = 1; kc = 1; idx = 2'(u - 10 * rl); rnd = 4'd10;
    end
    return {1'b0, 1'b0, 1'b0, e, mc, lp, kc, idx, rnd, 1'b1};
  endfunction

  // Model mode per instance: 0 idle, 1 busy (index t), 2 output held.
  int mode [2] = '{0, 0};
  int tix  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] <= 0;
        tix[k]  <= 0;
      end else if (mode[k] == 0) begin
        if (in_valid) begin
          mode[k] <= 1;
          tix[k]  <= 0;
        end
      end else if (mode[k] == 1) begin
        if (tix[k] + 1 == run_len(lat[k])) mode[k] <= 2;
        else tix[k] <= tix[k] + 1;
      end else begin
        if (out_ready) mode[k] <= 0;
      end
    end
  end

  function automatic logic [W-1:0] exp_now(input int k);
    if (mode[k] == 0) return {1'b1, 13'd0};
    if (mode[k] == 2) return {1'b0, 1'b1, 12'd0};
    return exp_run(lat[k], tix[k]);
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] exp_q[$];

  // On every cycle, compare both instances against the model. The key fields are
  // only meaningful while a column is requested or in IDLE.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] e, m;
        e = exp_now(k);
        m = '1;
        if (!e[7] && mode[k] != 0) m[6:1] = 6'd0;
        exp_q.push_back(e & m);
        checks++;
        if ((act[k] & m) !== exp_q.pop_front()) begin
          errors++;
          $display("FAIL cycle_out lat%0d cyc=%0d actual=%b required=%b", lat[k], cyc, act[k] & m, e & m);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_check(input string name, input int a, input int r);
    checks++;
    if (a != r) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, a, r);
    end
  endtask

  // Pulse in_valid for one cycle, then count edges from the accepting edge until
  // each instance raises out_valid. The wait is bounded.
  task automatic run_and_measure(output int l4, output int l6);
    int n;
    l4 = -1; l6 = -1;
    in_valid = 1;
    step(1);
    in_valid = 0;
    n = 0;
    while ((l4 < 0 || l6 < 0) && n < 400) begin
      if (ov4 && l4 < 0) l4 = n;
      if (ov6 && l6 < 0) l6 = n;
      step(1);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l4, l6, cnt_en, cnt_mc;
    int last4, last6, p4, p6;
    logic pv4, pv6;

    // Pin the schedule model against hand-counted totals.
    cnt_en = 0; cnt_mc = 0;
    for (int t = 0; t < run_len(4); t++) begin
      logic [W-1:0] v;
      v = exp_run(4, t);
      cnt_en += int'(v[10]);
      cnt_mc += int'(v[9]);
      if (v[8]) lit_check("model_en_loop_window", (t >= 81 && t <= 84) ? 1 : 0, 1);
    end
    lit_check("model_enable_count_l4", cnt_en, 85);
    lit_check("model_en_mc_count_l4", cnt_mc, 36);
    cnt_en = 0;
    for (int t = 0; t < run_len(6); t++) cnt_en += int'(exp_run(6, t)) >> 10 & 1;
    lit_check("model_enable_count_l6", cnt_en, 85);

    // Reset held for two cycles, then ten idle cycles checked on every cycle.
    rst = 1;
    step(2);
    chk_en = 1;
    rst = 0;
    step(1);
    lit_check("reset_vector_l4", int'(act[0]), int'({1'b1, 13'd0}));
    step(9);

    // Nominal run with the latency measured directly on the DUT.
    run_and_measure(l4, l6);
    lit_check("latency_l4", l4, 85);
    lit_check("latency_l6", l6, 105);

    // Backpressure: OUT is held while in_valid toggles randomly.
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      step(1);
      lit_check("hold_out_valid_l4", int'(ov4), 1);
    end
    in_valid = 0;
    out_ready = 1;
    step(1);
    out_ready = 0;
    lit_check("idle_after_hs_l4", int'(ir4), 1);
    step(2);

    // Abort during round 5 RET (SBOX_LAT=4): the busy index is 1+5*8+4+1 = 46.
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(46);
    rst = 1;
    step(1);
    rst = 0;
    lit_check("abort_idle_l4", int'(ir4), 1);
    step(3);
    run_and_measure(l4, l6);
    lit_check("latency_after_abort_l4", l4, 85);
    lit_check("latency_after_abort_l6", l6, 105);
    out_ready = 1;
    step(2);

    // Back-to-back with in_valid and out_ready tied high.
    in_valid = 1;
    last4 = -1; last6 = -1; p4 = 0; p6 = 0; pv4 = 0; pv6 = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (ov4 && !pv4) begin
        if (last4 >= 0) begin lit_check("period_l4", i - last4, 87); p4++; end
        last4 = i;
      end
      if (ov6 && !pv6) begin
        if (last6 >= 0) begin lit_check("period_l6", i - last6, 107); p6++; end
        last6 = i;
      end
      pv4 = ov4; pv6 = ov6;
    end
    lit_check("periods_seen", (p4 >= 3 && p6 >= 3) ? 1 : 0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 0; in_valid = 0; out_ready = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
